hbridge_pwm_driver: RTL and testbench

//   Parametrised N-channel H-bridge motor driver. One shared PWM period counter

---
 rtl/drive_pkg.sv | 21 ++
 rtl/pwm_channel.sv | 185 ++++++++++++++++++
 rtl/hbridge_pwm_driver.sv | 63 ++++++
 tb/tb_hbridge_pwm_driver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared codes for the H-bridge driver: direction commands, channel states, duty limits.
// Imported by pwm_channel and hbridge_pwm_driver.
package drive_pkg;

   localparam int DUTY_W       = 7;
   localparam int MAX_DUTY_DEF = 80;

   localparam logic [1:0] DIR_COAST = 2'b00;
   localparam logic [1:0] DIR_FWD   = 2'b01;
   localparam logic [1:0] DIR_REV   = 2'b10;
   localparam logic [1:0] DIR_BRAKE = 2'b11;

   typedef enum logic [2:0] {
      ST_COAST = 3'd0,
      ST_RUN   = 3'd1,
      ST_BRAKE = 3'd2,
      ST_DEAD  = 3'd3,
      ST_ARM   = 3'd4
   } ch_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One H-bridge channel: drive FSM, duty threshold latch, optional slew, registered pins.
// Optional duty slew limiting is built when HBRIDGE_PWM_RAMP_EN is defined.
module pwm_channel
   import drive_pkg::*;
#(
   parameter int CNT_W     = 20,
   parameter int DUTY_STEP = 6250,
   parameter int MAX_DUTY  = MAX_DUTY_DEF,
   parameter int DEAD_CYC  = 50000,
   parameter int RAMP_STEP = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  cnt,
   input  logic              wrap,
   input  logic              tick,
   input  logic [DUTY_W-1:0] duty,
   input  logic [1:0]        dir_cmd,
   output logic              bridge_en,
   output logic              bridge_a,
   output logic              bridge_b,
   output logic              busy
);

   localparam int PW  = DUTY_W + CNT_W;
   localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

   ch_state_t        state, state_nxt;
   logic [1:0]       dir_q, dir_nxt;
   logic [DCW-1:0]   dead_cnt;
   logic             dead_done;
   logic [PW-1:0]    thr;
   logic             pwm_cmp;
   logic             is_dir, opposite;
   logic             en_nxt, a_nxt, b_nxt, busy_nxt;

   function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
      return (d > DUTY_W'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : d;
   endfunction

   function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
      if (tgt > cur)
         return ((tgt - cur) > DUTY_W'(RAMP_STEP)) ? cur + DUTY_W'(RAMP_STEP) : tgt;
      else
         return ((cur - tgt) > DUTY_W'(RAMP_STEP)) ? cur - DUTY_W'(RAMP_STEP) : tgt;
   endfunction

   // Full-width product so thresholds at or beyond PERIOD are never truncated.
   function automatic logic [PW-1:0] scale(input logic [DUTY_W-1:0] d);
      return PW'(d) * PW'(DUTY_STEP);
   endfunction

   assign is_dir    = (dir_cmd == DIR_FWD) || (dir_cmd == DIR_REV);
   assign opposite  = is_dir && (dir_cmd != dir_q);
   assign dead_done = (dead_cnt == DCW'(DEAD_CYC - 1));
   assign pwm_cmp   = ({{DUTY_W{1'b0}}, cnt} < thr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_COAST;
         dir_q <= DIR_FWD;
      end else begin
         state <= state_nxt;
         dir_q <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir_q;
      case (state)
         ST_COAST: begin
            if (is_dir) begin
               state_nxt = ST_ARM;
               dir_nxt   = dir_cmd;
            end else if (dir_cmd == DIR_BRAKE) begin
               state_nxt = ST_BRAKE;
            end
         end
         ST_RUN: begin
            if (dir_cmd == DIR_COAST)      state_nxt = ST_COAST;
            else if (dir_cmd == DIR_BRAKE) state_nxt = ST_BRAKE;
            else if (opposite)             state_nxt = ST_DEAD;
         end
         ST_BRAKE: begin
            if (dir_cmd == DIR_COAST) state_nxt = ST_COAST;
            else if (is_dir)          state_nxt = ST_DEAD;
         end
         ST_DEAD: begin
            if (dir_cmd == DIR_COAST) begin
               state_nxt = ST_COAST;
            end else if (dead_done) begin
               if (is_dir) begin
                  state_nxt = ST_ARM;
                  dir_nxt   = dir_cmd;
               end else begin
                  state_nxt = ST_BRAKE;
               end
            end
         end
         ST_ARM: begin
            if (dir_cmd == DIR_COAST)      state_nxt = ST_COAST;
            else if (dir_cmd == DIR_BRAKE) state_nxt = ST_BRAKE;
            else if (opposite)             state_nxt = ST_DEAD;
            else if (tick)                 state_nxt = ST_RUN;
         end
         default: state_nxt = ST_COAST;
      endcase
   end

   // Pin values are decoded from the next state and registered, so pins never glitch.
   always_comb begin
      en_nxt   = 1'b0;
      a_nxt    = 1'b0;
      b_nxt    = 1'b0;
      busy_nxt = 1'b0;
      case (state_nxt)
         ST_RUN: begin
            en_nxt = pwm_cmp;
            a_nxt  = (dir_nxt == DIR_REV);
            b_nxt  = (dir_nxt == DIR_FWD);
         end
         ST_BRAKE: en_nxt = 1'b1;
         ST_DEAD: begin
            a_nxt    = bridge_a;
            b_nxt    = bridge_b;
            busy_nxt = 1'b1;
         end
         ST_ARM: begin
            a_nxt    = (dir_nxt == DIR_REV);
            b_nxt    = (dir_nxt == DIR_FWD);
            busy_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bridge_en <= 1'b0;
         bridge_a  <= 1'b0;
         bridge_b  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         bridge_en <= en_nxt;
         bridge_a  <= a_nxt;
         bridge_b  <= b_nxt;
         busy      <= busy_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                dead_cnt <= '0;
      else if (state != ST_DEAD) dead_cnt <= '0;
      else                       dead_cnt <= dead_cnt + DCW'(1);
   end

`ifdef HBRIDGE_PWM_RAMP_EN
   logic [DUTY_W-1:0] app;
   logic [DUTY_W-1:0] app_step;
   logic              hold_zero;

   assign app_step  = ramp_toward(app, sat_duty(duty));
   assign hold_zero = (state_nxt == ST_COAST) || (state_nxt == ST_BRAKE) ||
                      (state_nxt == ST_DEAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         app <= '0;
         thr <= '0;
      end else begin
         if (wrap)           thr <= scale(app_step);
         if (hold_zero)      app <= '0;
         else if (wrap)      app <= app_step;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    thr <= '0;
      else if (wrap) thr <= scale(sat_duty(duty));
   end
`endif

endmodule

// File: rtl/hbridge_pwm_driver.sv
// N-channel H-bridge PWM driver: shared period counter and tick, one pwm_channel per motor.
// Define HBRIDGE_PWM_RAMP_EN to build per-channel duty slew limiting.
module hbridge_pwm_driver
   import drive_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int CNT_W     = 20,
   parameter int PERIOD    = 625000,
   parameter int DUTY_STEP = 6250,
   parameter int MAX_DUTY  = MAX_DUTY_DEF,
   parameter int DEAD_CYC  = 50000,
   parameter int RAMP_STEP = 5
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic [DUTY_W*NUM_CH-1:0] duty,
   input  logic [2*NUM_CH-1:0]      dirCmd,
   output logic [NUM_CH-1:0]        hbEn,
   output logic [NUM_CH-1:0]        hbInA,
   output logic [NUM_CH-1:0]        hbInB,
   output logic                     periodTick,
   output logic [NUM_CH-1:0]        busy
);

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   assign wrap = (cnt == CNT_W'(PERIOD - 1));

   // Tick is registered from the wrap so it is low while held in reset even though cnt==0.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cnt        <= '0;
         periodTick <= 1'b0;
      end else begin
         cnt        <= wrap ? '0 : cnt + CNT_W'(1);
         periodTick <= wrap;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      pwm_channel #(
         .CNT_W     (CNT_W),
         .DUTY_STEP (DUTY_STEP),
         .MAX_DUTY  (MAX_DUTY),
         .DEAD_CYC  (DEAD_CYC),
         .RAMP_STEP (RAMP_STEP)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rstN),
         .cnt       (cnt),
         .wrap      (wrap),
         .tick      (periodTick),
         .duty      (duty[DUTY_W*ch +: DUTY_W]),
         .dir_cmd   (dirCmd[2*ch +: 2]),
         .bridge_en (hbEn[ch]),
         .bridge_a  (hbInA[ch]),
         .bridge_b  (hbInB[ch]),
         .busy      (busy[ch])
      );
   end

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Directed bench for hbridge_pwm_driver at PERIOD=100, DUTY_STEP=1, DEAD_CYC=10, RAMP_STEP=5.
// Channel 0 is exercised; channel 1 runs independently alongside (HBRIDGE_PWM_RAMP_EN selects ramp vectors).
module tb_hbridge_pwm_driver;

   logic        clk = 1'b0;
   logic        rstN;
   logic [13:0] duty;
   logic [3:0]  dirCmd;
   logic [1:0]  hbEn, hbInA, hbInB, busy;
   logic        periodTick;

   int tests = 0;
   int fails = 0;

   hbridge_pwm_driver #(
      .NUM_CH    (2),
      .CNT_W     (8),
      .PERIOD    (100),
      .DUTY_STEP (1),
      .MAX_DUTY  (80),
      .DEAD_CYC  (10),
      .RAMP_STEP (5)
   ) dut (
      .clk        (clk),
      .rstN       (rstN),
      .duty       (duty),
      .dirCmd     (dirCmd),
      .hbEn       (hbEn),
      .hbInA      (hbInA),
      .hbInB      (hbInB),
      .periodTick (periodTick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_tick();
      for (int n = 0; n < 400 && periodTick !== 1'b1; n++) @(negedge clk);
      check("tick_seen", 32'(periodTick), 1);
   endtask

   // Counts high cycles of each hbEn over one full period, starting on the tick cycle.
   task automatic measure(input int chg_at, input logic [6:0] chg_duty,
                          output int hi0, output int hi1);
      wait_tick();
      hi0 = 0;
      hi1 = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == chg_at) duty[6:0] = chg_duty;
         hi0 += 32'(hbEn[0]);
         hi1 += 32'(hbEn[1]);
         @(negedge clk);
      end
   endtask

   initial begin
      int h0, h1, held, en_hi, busy_lo, n;
      rstN   = 1'b0;
      duty   = '0;
      dirCmd = '0;
      repeat (3) @(negedge clk);
      check("rst_outs", 32'({hbEn, hbInA, hbInB, busy, periodTick}), 0);

`ifndef HBRIDGE_PWM_RAMP_EN
      duty   = {7'd20, 7'd40};
      dirCmd = {2'b10, 2'b01};
      rstN   = 1'b1;
      @(negedge clk);
      check("arm_a", 32'(hbInA), 32'b10);
      check("arm_b", 32'(hbInB), 32'b01);
      check("arm_busy", 32'(busy), 32'b11);
      check("arm_en", 32'(hbEn), 0);

      measure(-1, 7'd0, h0, h1);
      check("p1_ch0_40", h0, 40);
      check("p1_ch1_20", h1, 20);
      check("run_busy", 32'(busy), 0);
      measure(0, 7'd95, h0, h1);
      check("p2_ch0_40", h0, 40);
      measure(0, 7'd0, h0, h1);
      check("p3_clamp80", h0, 80);
      check("p3_ch1_20", h1, 20);
      measure(0, 7'd30, h0, h1);
      check("p4_duty0", h0, 0);
      measure(10, 7'd60, h0, h1);
      check("p5_keep30", h0, 30);
      measure(-1, 7'd0, h0, h1);
      check("p6_new60", h0, 60);

      // Reversal FWD -> REV at cnt=20
      repeat (20) @(negedge clk);
      check("rev_pre_en", 32'(hbEn[0]), 1);
      dirCmd[1:0] = 2'b10;
      held = 0;
      en_hi = 0;
      busy_lo = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 1) check("rev_en_off", 32'(hbEn[0]), 0);
         if (hbInA[0] == 1'b0 && hbInB[0] == 1'b1) held++;
         en_hi += 32'(hbEn[0]);
         busy_lo += 32'(!busy[0]);
      end
      check("rev_held10", held, 10);
      check("rev_new_ab", 32'({hbInA[0], hbInB[0]}), 32'b10);
      n = 0;
      while (periodTick !== 1'b1 && n < 300) begin
         @(negedge clk);
         en_hi += 32'(hbEn[0]);
         busy_lo += 32'(!busy[0]);
         n++;
      end
      check("rev_en_low", en_hi, 0);
      check("rev_busy_hi", busy_lo, 0);
      measure(-1, 7'd0, h0, h1);
      check("rev_run60", h0, 60);
      check("rev_ch1_20", h1, 20);
      check("rev_run_ab", 32'({hbInA[0], hbInB[0]}), 32'b10);

      // Brake at cnt=70, beyond the duty window
      repeat (70) @(negedge clk);
      dirCmd[1:0] = 2'b11;
      @(negedge clk);
      check("brake_en", 32'(hbEn[0]), 1);
      check("brake_ab", 32'({hbInA[0], hbInB[0]}), 0);
      check("brake_busy", 32'(busy[0]), 0);
      en_hi = 0;
      for (int k = 0; k < 120; k++) begin
         en_hi += 32'(hbEn[0]);
         @(negedge clk);
      end
      check("brake_solid", en_hi, 120);
      dirCmd[1:0] = 2'b00;
      @(negedge clk);
      check("coast_outs", 32'({hbEn[0], hbInA[0], hbInB[0], busy[0]}), 0);

      wait_tick();
      repeat (50) @(negedge clk);
      check("pre_rst_a1", 32'(hbInA[1]), 1);
`else
      duty   = {7'd0, 7'd0};
      dirCmd = {2'b00, 2'b01};
      rstN   = 1'b1;
      @(negedge clk);
      check("arm_b", 32'(hbInB), 32'b01);
      check("arm_busy", 32'(busy), 32'b01);
      measure(0, 7'd20, h0, h1);
      check("ramp_p0", h0, 0);
      check("ramp_ch1", h1, 0);
      measure(-1, 7'd0, h0, h1);
      check("ramp_p1_5", h0, 5);
      measure(-1, 7'd0, h0, h1);
      check("ramp_p2_10", h0, 10);
      measure(-1, 7'd0, h0, h1);
      check("ramp_p3_15", h0, 15);
      measure(-1, 7'd0, h0, h1);
      check("ramp_p4_20", h0, 20);
      measure(-1, 7'd0, h0, h1);
      check("ramp_p5_20", h0, 20);
      wait_tick();
      repeat (50) @(negedge clk);
      check("pre_rst_b0", 32'(hbInB[0]), 1);
`endif

      rstN = 1'b0;
      #1;
      check("async_rst", 32'({hbEn, hbInA, hbInB, busy, periodTick}), 0);
      repeat (3) @(negedge clk);
      check("rst_hold", 32'({hbEn, hbInA, hbInB, busy, periodTick}), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
